uart_rx_byte: RTL and testbench

- Asynchronous serial receiver, LSB-first, 1 start bit, DataBits data bits, 1 stop bit.
- It is the receive-side counterpart to the existing bit-serial UART transmit path.
- It sits between the board's RX pin and the command/clock-setting logic.
- It oversamples the line on the system clock, validates the start bit at mid-bit, samples each data bit at mid-bit, checks the stop bit, and presents the received word with a one-cycle strobe.

---
 rtl/uart_rx_byte.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte -- oversampling asynchronous serial receiver.
//
// Frame: 1 start bit, DataBits data bits (LSB first), optional parity bit,
// 1 stop bit. The line is double-flopped into the clock domain. The start
// bit is confirmed at mid-bit, then every following bit is sampled one
// full bit time later, which lands each sample at mid-bit.
//
// Optional feature macro: UART_RX_PARITY_EN
//   Adds parameter ParityOdd and output parityError, plus a Parity state
//   between Data and Stop.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   rx          raw serial line, idle high, asynchronous
//   data        last correctly framed word, bit 0 = first received bit
//   dataValid   one-cycle strobe when data updates
//   frameError  one-cycle strobe on a bad (low) stop bit
//   parityError one-cycle strobe on parity mismatch (parity build only)
//   busy        high whenever the receiver is not Idle
module uart_rx_byte #(
  parameter int ClockFrequency = 1000000,
  parameter int BaudRate       = 9600,
  parameter int DataBits       = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit ParityOdd      = 1'b0
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx,
  output logic [DataBits-1:0] data,
  output logic                dataValid,
  output logic                frameError,
`ifdef UART_RX_PARITY_EN
  output logic                parityError,
`endif
  output logic                busy
);

  localparam int BitTicks  = ClockFrequency / BaudRate;
  localparam int HalfTicks = BitTicks / 2;
  localparam int CW = (BitTicks > 2) ? $clog2(BitTicks) : 2;
  localparam int IW = $clog2(DataBits);
  localparam logic [CW-1:0] CntLast = CW'(BitTicks - 1);
  localparam logic [CW-1:0] CntHalf = CW'(HalfTicks - 1);
  localparam logic [IW-1:0] IdxLast = IW'(DataBits - 1);

  if (BitTicks < 4) begin : g_bad_rate
    $error("uart_rx_byte: ClockFrequency/BaudRate must be at least 4");
  end
  if (DataBits < 5 || DataBits > 9) begin : g_bad_width
    $error("uart_rx_byte: DataBits must be in 5..9");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync_q, sync_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [DataBits-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                perr_q, perr_d;
  logic                pbad_q, pbad_d;
`endif
  logic                rx_sync;

  // Two-flop synchronizer; reset high so a released reset looks like idle.
  assign sync_d  = {sync_q[0], rx};
  assign rx_sync = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = 1'b0;
    pbad_d  = pbad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_sync) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          idx_d   = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_d = rx_sync ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CntLast) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync;
          if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          // Even parity: data bits plus parity bit XOR to zero.
          pbad_d  = rx_sync ^ (^shift_q) ^ ParityOdd;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_sync) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (pbad_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must not look like a new start bit.
        if (rx_sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pbad_q  <= pbad_d;
`endif
    end
  end

  assign data       = data_q;
  assign dataValid  = valid_q;
  assign frameError = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parityError = perr_q;
`endif
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit (HalfTicks = 8).
// A negedge monitor logs every output strobe with its cycle number; each
// scenario task drives the line and compares the log against hand-computed
// frame timing (strobe in the cycle after edge k+154, or k+170 with parity).
module tb_uart_rx_byte;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       dataValid;
  logic       frameError;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parityError;
`endif

  uart_rx_byte #(
    .ClockFrequency(1600000),
    .BaudRate      (100000),
    .DataBits      (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .dataValid (dataValid),
    .frameError(frameError),
`ifdef UART_RX_PARITY_EN
    .parityError(parityError),
`endif
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int both_hi = 0;

  // Strobe log: kind 0 = dataValid, 1 = frameError, 2 = parityError.
  int         ev_cyc[$];
  int         ev_kind[$];
  logic [7:0] ev_data[$];
  logic       ev_busy[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (dataValid && frameError) both_hi++;
    if (dataValid) begin
      ev_cyc.push_back(cyc); ev_kind.push_back(0);
      ev_data.push_back(data); ev_busy.push_back(busy);
    end
    if (frameError) begin
      ev_cyc.push_back(cyc); ev_kind.push_back(1);
      ev_data.push_back(data); ev_busy.push_back(busy);
    end
`ifdef UART_RX_PARITY_EN
    if (parityError) begin
      ev_cyc.push_back(cyc); ev_kind.push_back(2);
      ev_data.push_back(data); ev_busy.push_back(busy);
    end
`endif
  end

  task automatic clear_log();
    ev_cyc.delete(); ev_kind.delete(); ev_data.delete(); ev_busy.delete();
  endtask

  // Called at a negedge; the next posedge is edge k. Leaves the line at the
  // stop value and returns at the negedge after the last stop-bit edge.
  task automatic send_frame(input logic [8:0] bits, input int nb,
                            input logic stop_bit, output int k);
    rx = 1'b0;
    k  = cyc + 1;
    repeat (16) @(negedge clock);
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      repeat (16) @(negedge clock);
    end
    rx = stop_bit;
    repeat (16) @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
    checks++; if (dataValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dataValid); end
    checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frameError); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b1;
    repeat (10) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_glitch();
    clear_log();
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    checks++; if (ev_cyc.size() != 0) begin errors++; $display("FAIL glitch_events got=%0d exp=0", ev_cyc.size()); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL glitch_data got=%h exp=00", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_frame();
    int k;
    clear_log();
    fork
      send_frame(9'h0A5, 8, 1'b1, k);
      begin
        repeat (60) @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid got=%b exp=1", busy); end
      end
    join
    repeat (20) @(negedge clock);
    checks++;
    if (ev_cyc.size() != 1) begin
      errors++; $display("FAIL single_count got=%0d exp=1", ev_cyc.size());
    end else begin
      checks++; if (ev_kind[0] != 0) begin errors++; $display("FAIL single_kind got=%0d exp=0", ev_kind[0]); end
      checks++; if (ev_cyc[0] != k + 154) begin errors++; $display("FAIL single_cycle got=%0d exp=%0d", ev_cyc[0], k + 154); end
      checks++; if (ev_data[0] !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", ev_data[0]); end
      checks++; if (ev_busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b exp=0", ev_busy[0]); end
    end
  endtask

  task automatic test_frame_error();
    int k;
    clear_log();
    send_frame(9'h03C, 8, 1'b0, k);
    repeat (40) @(negedge clock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low_line got=%b exp=1", busy); end
    checks++;
    if (ev_cyc.size() != 1) begin
      errors++; $display("FAIL ferr_count got=%0d exp=1", ev_cyc.size());
    end else begin
      checks++; if (ev_kind[0] != 1) begin errors++; $display("FAIL ferr_kind got=%0d exp=1", ev_kind[0]); end
      checks++; if (ev_cyc[0] != k + 154) begin errors++; $display("FAIL ferr_cycle got=%0d exp=%0d", ev_cyc[0], k + 154); end
    end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept got=%h exp=a5", data); end
    rx = 1'b1;
    repeat (5) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got=%b exp=0", busy); end
    repeat (200) @(negedge clock);
    checks++; if (ev_cyc.size() != 1) begin errors++; $display("FAIL ferr_no_retrigger got=%0d exp=1", ev_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    int k0, k1, k2;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h55;
    clear_log();
    send_frame(9'h000, 8, 1'b1, k0);
    send_frame(9'h0FF, 8, 1'b1, k1);
    send_frame(9'h055, 8, 1'b1, k2);
    repeat (20) @(negedge clock);
    checks++; if (k1 - k0 != 160 || k2 - k1 != 160) begin errors++; $display("FAIL b2b_gap got=%0d,%0d exp=160", k1 - k0, k2 - k1); end
    checks++;
    if (ev_cyc.size() != 3) begin
      errors++; $display("FAIL b2b_count got=%0d exp=3", ev_cyc.size());
    end else begin
      checks++; if (ev_cyc[0] != k0 + 154) begin errors++; $display("FAIL b2b_cycle0 got=%0d exp=%0d", ev_cyc[0], k0 + 154); end
      for (int i = 0; i < 3; i++) begin
        checks++; if (ev_kind[i] != 0) begin errors++; $display("FAIL b2b_kind%0d got=%0d exp=0", i, ev_kind[i]); end
        checks++; if (ev_data[i] !== exp_d[i]) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, ev_data[i], exp_d[i]); end
        if (i > 0) begin
          checks++; if (ev_cyc[i] - ev_cyc[i-1] != 160) begin errors++; $display("FAIL b2b_spacing%0d got=%0d exp=160", i, ev_cyc[i] - ev_cyc[i-1]); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int k;
    logic [7:0] v;
    v = 8'h81;
    clear_log();
    rx = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rx = v[i];
      repeat (16) @(negedge clock);
    end
    rx = v[3];
    repeat (8) @(negedge clock);
    reset = 1'b0;
    rx = 1'b1;
    @(negedge clock);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data got=%h exp=00", data); end
    checks++; if (dataValid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", dataValid); end
    checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL rstmid_ferr got=%b exp=0", frameError); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    checks++; if (ev_cyc.size() != 0) begin errors++; $display("FAIL rstmid_no_pulse got=%0d exp=0", ev_cyc.size()); end
    send_frame(9'h07E, 8, 1'b1, k);
    repeat (20) @(negedge clock);
    checks++;
    if (ev_cyc.size() != 1) begin
      errors++; $display("FAIL rstmid_next_count got=%0d exp=1", ev_cyc.size());
    end else begin
      checks++; if (ev_data[0] !== 8'h7E || ev_kind[0] != 0) begin errors++; $display("FAIL rstmid_next_data got=%h/%0d exp=7e/0", ev_data[0], ev_kind[0]); end
      checks++; if (ev_cyc[0] != k + 154) begin errors++; $display("FAIL rstmid_next_cycle got=%0d exp=%0d", ev_cyc[0], k + 154); end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int k;
    logic [7:0] prev;
    prev = data;
    clear_log();
    // 0x07 has three ones, so even parity needs a 1; send 0 first.
    send_frame({1'b0, 8'h07}, 9, 1'b1, k);
    repeat (20) @(negedge clock);
    checks++;
    if (ev_cyc.size() != 1) begin
      errors++; $display("FAIL par_bad_count got=%0d exp=1", ev_cyc.size());
    end else begin
      checks++; if (ev_kind[0] != 2) begin errors++; $display("FAIL par_bad_kind got=%0d exp=2", ev_kind[0]); end
      checks++; if (ev_cyc[0] != k + 170) begin errors++; $display("FAIL par_bad_cycle got=%0d exp=%0d", ev_cyc[0], k + 170); end
    end
    checks++; if (data !== prev) begin errors++; $display("FAIL par_bad_data got=%h exp=%h", data, prev); end
    clear_log();
    send_frame({1'b1, 8'h07}, 9, 1'b1, k);
    repeat (20) @(negedge clock);
    checks++;
    if (ev_cyc.size() != 1) begin
      errors++; $display("FAIL par_good_count got=%0d exp=1", ev_cyc.size());
    end else begin
      checks++; if (ev_kind[0] != 0 || ev_data[0] !== 8'h07) begin errors++; $display("FAIL par_good_data got=%h/%0d exp=07/0", ev_data[0], ev_kind[0]); end
      checks++; if (ev_cyc[0] != k + 170) begin errors++; $display("FAIL par_good_cycle got=%0d exp=%0d", ev_cyc[0], k + 170); end
    end
  endtask
`endif

  task automatic test_exclusive();
    checks++; if (both_hi != 0) begin errors++; $display("FAIL exclusive_strobes got=%0d exp=0", both_hi); end
  endtask

  initial begin
    test_reset();
    test_glitch();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    test_single_frame();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
`endif
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
